// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the multi-cycle MIPS main control
package mips_pkg;

  // FSM state encodings; the numeric values are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JR        = 4'd12,
    S_JAL       = 4'd13,
    S_FAULT     = 4'd14
  } state_t;

  // Opcodes, instruction[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_OP4I  = 4'b0110;
  localparam logic [3:0] OP_JAL   = 4'b0111;

  // R-type funct value that turns the instruction into a register jump
  localparam logic [3:0] FUNCT_JR = 4'b1000;

  // ALUOp encodings consumed by the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b11;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP4   = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b00;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that wait on the memory ready handshake
  function automatic logic is_mem_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_mem_wait.sv
// rtl/mips_mem_wait.sv - bounded wait counter for memory ready handshakes
module mips_mem_wait #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic mem_ready,
  output logic timeout
);

  // The limit is checked against the count before this cycle's increment, so
  // timeout fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Clear on entry to a waiting state, count every cycle the access stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (start) begin
      wait_cnt <= 8'd0;
    end else if (busy && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A ready in the limit cycle completes the access instead of faulting
  assign timeout = busy && !mem_ready && (wait_cnt == LIMIT);

endmodule

// File: rtl/mips_main_control.sv
// rtl/mips_main_control.sv - multi-cycle main control FSM; JAL gated by MIPS_CTRL_JAL_EN
module mips_main_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [3:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] op_q;
  logic [1:0] fault_code_d;
  logic       enter_fault;
  logic       wait_start;
  logic       wait_busy;
  logic       timeout;

  assign wait_busy  = is_mem_wait_state(state_q);
  assign wait_start = (state_d != state_q) && is_mem_wait_state(state_d);

  mips_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk      (clk),
    .reset    (reset),
    .start    (wait_start),
    .busy     (wait_busy),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Next-state selection and the fault cause that goes with entering FAULT
  always_comb begin
    state_d      = state_q;
    fault_code_d = FAULT_NONE;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = (funct == FUNCT_JR) ? S_JR : S_EXECUTE;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI,
          OP_OP4I:  state_d = S_IMM_EXEC;
          OP_J:     state_d = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:   state_d = S_JAL;
`endif
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_JR:       state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase
  end

  assign enter_fault = (state_d == S_FAULT) && (state_q != S_FAULT);

  // State register, opcode capture in DECODE and sticky first-fault record
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= 4'd0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (enter_fault) begin
        fault      <= 1'b1;
        fault_code <= fault_code_d;
      end
    end
  end

  assign state = state_q;

  // Moore output decode; write enables are forced low while reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_FUNCT;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_q == OP_OP4I) ? ALU_OP4 : ALU_ADD;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_REGA;
      end
`ifdef MIPS_CTRL_JAL_EN
      S_JAL: begin
        // Link PC into r7 via the datapath link mux while jumping
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_main_control.sv
// tb/tb_mips_main_control.sv - self-checking bench for mips_main_control
module tb_mips_main_control;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [3:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       i_or_d, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       fault;
  logic [1:0] fault_code;
  logic [3:0] state;

  mips_main_control #(
    .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .fault        (fault),
    .fault_code   (fault_code),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    ctrl_t      ctrl;
    logic       rdy;
    logic       flt;
    logic [1:0] code;
  } rec_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [3:0]  fn;
    int          n;
    logic [39:0] st;
    logic [9:0]  rdy;
  } vec_t;

  ctrl_t act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                     i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op};

  rec_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Expected control word for a state, straight from the state table
  function automatic ctrl_t model(logic [3:0] st, logic [3:0] op, logic rdy);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 2'b11; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  begin c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      4'd3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd5:  begin c.mem_write = 1; c.i_or_d = 1; end
      4'd6:  begin c.alu_src_a = 1; end
      4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 4'b0110) ? 2'b10 : 2'b11; end
      4'd11: begin c.reg_write = 1; end
      4'd12: begin c.pc_write = 1; c.pc_source = 2'b11; end
      4'd13: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [3:0] st, logic rdy, logic flt, logic [1:0] code);
    rec_t r;
    r.st   = st;
    r.ctrl = model(st, opcode, rdy);
    r.rdy  = rdy;
    r.flt  = flt;
    r.code = code;
    sb.push_back(r);
  endtask

  // Starts at a negedge: drive, sample 1ns later, then move to the next negedge
  task automatic drain(string tag);
    int i;
    rec_t r;
    i = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.rdy;
      #1;
      check($sformatf("%s[%0d].state", tag, i), int'(state), int'(r.st));
      check($sformatf("%s[%0d].ctrl", tag, i), int'(act_ctrl), int'(r.ctrl));
      check($sformatf("%s[%0d].fault", tag, i), int'(fault), int'(r.flt));
      check($sformatf("%s[%0d].code", tag, i), int'(fault_code), int'(r.code));
      @(negedge clk);
      i++;
    end
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check({tag, ".state"}, int'(state), 0);
    repeat (2) @(negedge clk);
    #1;
    check({tag, ".state_held"}, int'(state), 0);
    check({tag, ".fault"}, int'(fault), 0);
    check({tag, ".code"}, int'(fault_code), 0);
    check({tag, ".writes"}, int'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_vec(string name, logic [3:0] op, logic [3:0] fn, int n,
                         logic [39:0] st, logic [9:0] rdy);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.fn   = fn;
    v.n    = n;
    v.st   = st;
    v.rdy  = rdy;
    vecs.push_back(v);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 4'd0;
    funct     = 4'd0;

    // name, opcode, funct, cycles, states (MSB first), mem_ready per cycle
    add_vec("r_add",   4'b0000, 4'b0000, 4, 40'h0167000000, 10'b1111111111);
    add_vec("lw_wait", 4'b0001, 4'b0000, 8, 40'h0123333400, 10'b1110001111);
    add_vec("sw",      4'b0010, 4'b0000, 4, 40'h0125000000, 10'b1111111111);
    add_vec("beq",     4'b0011, 4'b0000, 3, 40'h0180000000, 10'b1111111111);
    add_vec("addi",    4'b0100, 4'b0000, 4, 40'h01AB000000, 10'b1111111111);
    add_vec("op4i",    4'b0110, 4'b0000, 4, 40'h01AB000000, 10'b1111111111);
    add_vec("j",       4'b0101, 4'b0000, 3, 40'h0190000000, 10'b1111111111);
    add_vec("jr",      4'b0000, 4'b1000, 3, 40'h01C0000000, 10'b1111111111);
    add_vec("r_sub",   4'b0000, 4'b0010, 4, 40'h0167000000, 10'b1111111111);
    add_vec("fetch_w", 4'b0100, 4'b0000, 6, 40'h0001AB0000, 10'b0011111111);
`ifdef MIPS_CTRL_JAL_EN
    add_vec("jal",     4'b0111, 4'b0000, 3, 40'h01D0000000, 10'b1111111111);
`endif

    do_reset("reset0");

    foreach (vecs[k]) begin
      opcode = vecs[k].op;
      funct  = vecs[k].fn;
      for (int i = 0; i < vecs[k].n; i++) begin
        push(vecs[k].st[39-4*i -: 4], vecs[k].rdy[9-i], 1'b0, 2'b00);
      end
      drain(vecs[k].name);
    end

    // Illegal opcode
    opcode = 4'b1111;
    funct  = 4'b0000;
    push(4'd0, 1'b1, 1'b0, 2'b00);
    push(4'd1, 1'b1, 1'b0, 2'b00);
    push(4'd14, 1'b1, 1'b1, 2'b01);
    push(4'd14, 1'b0, 1'b1, 2'b01);
    push(4'd14, 1'b1, 1'b1, 2'b01);
    drain("illegal");
    do_reset("reset1");

`ifndef MIPS_CTRL_JAL_EN
    // Opcode 0111 without the JAL option
    opcode = 4'b0111;
    push(4'd0, 1'b1, 1'b0, 2'b00);
    push(4'd1, 1'b1, 1'b0, 2'b00);
    push(4'd14, 1'b1, 1'b1, 2'b01);
    push(4'd14, 1'b1, 1'b1, 2'b01);
    drain("jal_off");
    do_reset("reset2");
`endif

    // SW with mem_ready stuck low: four wait cycles, then timeout fault
    opcode = 4'b0010;
    push(4'd0, 1'b1, 1'b0, 2'b00);
    push(4'd1, 1'b1, 1'b0, 2'b00);
    push(4'd2, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < TIMEOUT; i++) push(4'd5, 1'b0, 1'b0, 2'b00);
    push(4'd14, 1'b0, 1'b1, 2'b10);
    push(4'd14, 1'b1, 1'b1, 2'b10);
    push(4'd14, 1'b0, 1'b1, 2'b10);
    drain("sw_tmo");
    do_reset("reset3");

    // Reset pulse in MEM_WRITE while the write is still pending
    opcode = 4'b0010;
    push(4'd0, 1'b1, 1'b0, 2'b00);
    push(4'd1, 1'b1, 1'b0, 2'b00);
    push(4'd2, 1'b1, 1'b0, 2'b00);
    push(4'd5, 1'b0, 1'b0, 2'b00);
    push(4'd5, 1'b0, 1'b0, 2'b00);
    drain("mid_pre");
    mem_ready = 1'b0;
    #1;
    check("mid.state_before", int'(state), 5);
    check("mid.mem_write_before", int'(mem_write), 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid.state_after", int'(state), 0);
    check("mid.mem_write_after", int'(mem_write), 0);
    check("mid.fault_after", int'(fault), 0);
    @(negedge clk);
    reset = 1'b0;
    opcode = 4'b0100;
    push(4'd0, 1'b1, 1'b0, 2'b00);
    push(4'd1, 1'b1, 1'b0, 2'b00);
    push(4'd10, 1'b1, 1'b0, 2'b00);
    push(4'd11, 1'b1, 1'b0, 2'b00);
    push(4'd0, 1'b0, 1'b0, 2'b00);
    drain("mid_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multi-cycle main control FSM for the 16-bit MIPS datapath. It decodes the 4-bit opcode, and the funct field where needed, and sequences the datapath through fetch, decode, execute, memory and write-back. It drives the 2-bit `alu_op` consumed by the ALU control decoder and handles JR itself. Memory accesses use a ready handshake with a bounded timeout; faults are reported on sticky status outputs.

## Interface
- `MEM_TIMEOUT`, default 16: max cycles spent waiting on `mem_ready` in any memory state before a timeout fault; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  instruction[15:12], sampled from the IR in DECODE.
- `funct`  in  4  instruction[3:0], sampled from the IR in DECODE.
- `mem_ready`  in  1  memory completes the current read or write in this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  datapath enables.
- `i_or_d`, `mem_to_reg`, `reg_dst`, `alu_src_a`  out  1 each  mux selects.
- `alu_src_b`  out  2  00 = regB, 01 = const 1, 10 = sign-extended immediate.
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = regA (JR).
- `alu_op`  out  2  11 = add, 01 = subtract, 10 = op4, 00 = use funct.
- `fault`  out  1  sticky; cleared only by `reset`.
- `fault_code`  out  2  01 = illegal opcode, 10 = memory timeout; holds the first fault.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 LW
  - 0010 SW
  - 0011 BEQ
  - 0100 ADDI
  - 0101 J
  - 0110 op4-immediate (ALUOp 10)
  - 0111 JAL (see Configuration)
  - all others illegal
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, JR 12, JAL 13, FAULT 14.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=11, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`. Advance to DECODE on `mem_ready`.
- DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=11 (branch target precompute). Next state by opcode:
  - R-type with funct 1000 -> JR; other R-type -> EXECUTE
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - ADDI, 0110 -> IMM_EXEC
  - J -> JUMP
  - illegal -> FAULT with code 01
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Go to MEM_WB on `mem_ready`.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Go to FETCH on `mem_ready`.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00. Next ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next FETCH.
- IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10. `alu_op`=11 for ADDI, 10 for opcode 0110. Next IMM_WB.
- IMM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Next FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Next FETCH.
- JR: `pc_write`=1, `pc_source`=11. Next FETCH.
- FAULT: all enables 0; the FSM stays here until `reset`.
- Wait counter (8 bits):
  - cleared on entry to FETCH, MEM_READ or MEM_WRITE;
  - increments each cycle those states see `mem_ready`=0;
  - if it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is FAULT with code 10;
  - `mem_ready` in the same cycle as the limit wins, and the access completes.
- All outputs not listed for a state are 0.

## Timing
- Outputs are Moore, decoded from `state`; `ir_write` and `pc_write` in FETCH are additionally qualified by `mem_ready`.
- While `reset` is high:
  - `state`=FETCH, `fault`=0, `fault_code`=00, wait counter 0;
  - every write enable (`pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`) is forced to 0.
- Reset asserted mid-instruction aborts immediately; there is no partial write-back after release.
- Cycle counts with zero-wait memory:
  - R-type and immediate: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ, J and JR: 3 cycles
- Each memory wait cycle adds 1.
- `fault` rises in the cycle FAULT is entered and holds. A second fault cannot occur, because FAULT is absorbing.

## Configuration
- `MIPS_CTRL_JAL_EN` defined:
  - opcode 0111 goes DECODE -> JAL;
  - JAL drives `pc_write`=1, `pc_source`=10, `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 (links PC into r7 through the datapath link mux), then returns to FETCH; 3 cycles total.
- Undefined: opcode 0111 is illegal (FAULT, code 01), and state 13 is unreachable.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants
  - state encodings
  - ALUOp constants (11 add, 01 sub, 10 op4, 00 funct)
  - `alu_src_b` and `pc_source` select constants
  - JR funct value 1000
- One sub-module `mips_mem_wait`: the timeout counter, with inputs `start`, `busy` and `mem_ready`, and output `timeout`.
- Next-state logic and output decode stay in the top module.

## Test plan
- R-type add, opcode 0000 funct 0000, `mem_ready`=1 every cycle -> states 0,1,6,7,0; `alu_op`=00 in EXECUTE; `reg_write`=1, `reg_dst`=1 in ALU_WB.
- LW with `mem_ready` held low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; `reg_write`=1, `mem_to_reg`=1 once.
- BEQ -> `alu_op`=01, `pc_write_cond`=1, `pc_source`=01 in BRANCH. JR (0000/1000) -> state 12, `pc_source`=11, `pc_write`=1.
- `MEM_TIMEOUT`=4, SW with `mem_ready` stuck at 0 -> FAULT after 4 wait cycles; `fault`=1, `fault_code`=10; `mem_write` low from then on.
- Opcode 1111 -> FAULT, code 01. Opcode 0111 -> state 13 with `MIPS_CTRL_JAL_EN`, else FAULT code 01.
- Reset pulse asserted in MEM_WRITE while `mem_ready`=0 -> immediate FETCH, `mem_write`=0 in the same cycle, `fault` cleared.
